// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller: digit count, common-line
// encodings, scan state encoding and slot-length helpers.
package fnd_pkg;

  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned POS_W       = 2;
  localparam logic [3:0]  FND_COM_OFF = 4'b1111;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Clock cycles per digit slot.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // Active-low common pattern for a position, honouring the per-position blank.
  function automatic logic [3:0] com_for(input logic [POS_W-1:0] pos,
                                         input logic [3:0]       mask);
    return mask[pos] ? FND_COM_OFF : ~(4'b0001 << pos);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-DIV slot counter with run enable and synchronous active-low clear.
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-low clear
//   i_enable       count enable; low clears the count to 0
//   o_cnt_q        current count, 0..DIV-1
//   o_slot_end_c   high while enabled on the last cycle of a slot
//   o_blank_end_c  high while enabled on the last blanking cycle
module scan_prescaler #(
  parameter int unsigned DIV          = 10,
  parameter int unsigned BLANK_CYCLES = 3,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_cnt_q,
  output logic             o_slot_end_c,
  output logic             o_blank_end_c
);

  // Clamp so the compare constant stays legal when blanking is disabled.
  localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  logic [CNT_W-1:0] cnt_d;

  // Strobes and next count.
  always_comb begin
    cnt_d         = o_cnt_q;
    o_slot_end_c  = i_enable && (o_cnt_q == CNT_W'(DIV - 1));
    o_blank_end_c = (BLANK_CYCLES != 0) && i_enable &&
                    (o_cnt_q == CNT_W'(BLANK_LAST));
    if (!i_enable || o_slot_end_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = o_cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_cnt_q <= '0;
    end else begin
      o_cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexing scan controller for a 4-digit 7-segment display. Each
// digit slot opens with an all-off blanking window, then drives the common
// line of the current position unless that position is masked.
// Ports:
//   i_clk            system clock
//   i_reset          synchronous active-low reset
//   i_enable         scan run enable; low freezes position and blanks
//   i_blank_mask     per-position blank (bit p blanks position p)
//   o_digitPosition  current digit position (0 = ones digit)
//   o_fndCom         active-low digit commons, bit p = position p
//   o_scanTick       one-cycle pulse on every position advance
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [3:0] i_blank_mask,
  output logic [1:0] o_digitPosition,
  output logic [3:0] o_fndCom,
  output logic       o_scanTick
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, SCAN_HZ);
  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_chk
    $error("fnd_scan_controller: CLK_HZ/SCAN_HZ must be at least 2");
  end
  if (BLANK_CYCLES >= DIV) begin : g_blank_chk
    $error("fnd_scan_controller: BLANK_CYCLES must be less than CLK_HZ/SCAN_HZ");
  end

  logic [CNT_W-1:0] cnt;
  logic             slot_end_c;
  logic             blank_end_c;

  scan_state_e      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [3:0]       com_q, com_d;
  logic             tick_q, tick_d;

  scan_prescaler #(
    .DIV          (DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_prescaler (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .o_cnt_q       (cnt),
    .o_slot_end_c  (slot_end_c),
    .o_blank_end_c (blank_end_c)
  );

  // State, position and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= BLANK;
      pos_q   <= '0;
      com_q   <= FND_COM_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      com_q   <= com_d;
      tick_q  <= tick_d;
    end
  end

  // Next state and outputs. With zero blanking a fresh slot (cnt==0 out of
  // reset or re-enable) goes straight to drive on its first enabled edge.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    com_d   = com_q;
    tick_d  = 1'b0;
    if (!i_enable) begin
      state_d = BLANK;
      com_d   = FND_COM_OFF;
    end else if (slot_end_c) begin
      pos_d  = pos_q + POS_W'(1);
      tick_d = 1'b1;
      if (BLANK_CYCLES > 0) begin
        state_d = BLANK;
        com_d   = FND_COM_OFF;
      end else begin
        state_d = DRIVE;
        com_d   = com_for(pos_d, i_blank_mask);
      end
    end else if (state_q == BLANK &&
                 (blank_end_c || (BLANK_CYCLES == 0 && cnt == '0))) begin
      state_d = DRIVE;
      com_d   = com_for(pos_q, i_blank_mask);
    end
  end

  assign o_digitPosition = pos_q;
  assign o_fndCom        = com_q;
  assign o_scanTick      = tick_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller (DIV=10, BLANK_CYCLES=3) with a
// second zero-blanking instance. Expected scan ticks go into a scoreboard
// queue; a monitor pops and compares on every o_scanTick pulse.
module tb_fnd_scan_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] mask;
  logic [3:0] mask0;
  logic [1:0] pos, pos0;
  logic [3:0] com, com0;
  logic       tick, tick0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.CLK_HZ(20), .SCAN_HZ(2), .BLANK_CYCLES(3)) dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_enable        (en),
    .i_blank_mask    (mask),
    .o_digitPosition (pos),
    .o_fndCom        (com),
    .o_scanTick      (tick)
  );

  fnd_scan_controller #(.CLK_HZ(20), .SCAN_HZ(2), .BLANK_CYCLES(0)) dut0 (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_enable        (en),
    .i_blank_mask    (mask0),
    .o_digitPosition (pos0),
    .o_fndCom        (com0),
    .o_scanTick      (tick0)
  );

  typedef struct {
    int         cyc;
    logic [1:0] pos;
    logic [3:0] com;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_tick = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every tick must match the head of the queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
      check("tick_missing", 32'(cyc), 32'(sb_q[0].cyc));
      void'(sb_q.pop_front());
    end
    if (tick) begin
      check("tick_width", 32'(prev_tick), 32'd0);
      if (sb_q.size() == 0) begin
        check("tick_unexpected", 32'(cyc), 32'hffff_ffff);
      end else begin
        e = sb_q.pop_front();
        check("tick_cycle", 32'(cyc), 32'(e.cyc));
        check("tick_pos",   32'(pos), 32'(e.pos));
        check("tick_com",   32'(com), 32'(e.com));
      end
    end
    prev_tick = tick;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_main(input string name, input logic [1:0] p,
                          input logic [3:0] c);
    check({name, "_pos"}, 32'(pos), 32'(p));
    check({name, "_com"}, 32'(com), 32'(c));
  endtask

  initial begin : stim
    int t0;
    int t1;
    exp_t e;
    rst_n = 1'b0;
    en    = 1'b0;
    mask  = 4'b0000;
    mask0 = 4'b0000;
    repeat (5) step();

    // Reset state
    chk_main("reset", 2'd0, 4'b1111);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset0_com", 32'(com0), 32'hf);

    rst_n = 1'b1;
    en    = 1'b1;
    t0    = cyc;
    for (int i = 1; i <= 6; i++) begin
      e.cyc = t0 + 10 * i;
      e.pos = 2'(i % 4);
      e.com = 4'b1111;
      sb_q.push_back(e);
    end

    // Start, wrap and mask; zero-blank instance checked alongside
    for (int k = 1; k <= 40; k++) begin
      step();
      check("zb_never_off", 32'(com0 == 4'b1111), 32'd0);
      case (k)
        1:  begin chk_main("start_e1", 2'd0, 4'b1111);
                  check("zb_e1_com", 32'(com0), 32'he); end
        2:  chk_main("start_e2", 2'd0, 4'b1111);
        3:  chk_main("start_e3", 2'd0, 4'b1110);
        9:  check("zb_e9_tick", 32'(tick0), 32'd0);
        10: begin check("zb_e10_com", 32'(com0), 32'hd);
                  check("zb_e10_tick", 32'(tick0), 32'd1); end
        13: chk_main("pos1_drive", 2'd1, 4'b1101);
        15: mask = 4'b1000;
        20: check("zb_e20_com", 32'(com0), 32'hb);
        23: chk_main("pos2_drive", 2'd2, 4'b1011);
        30: check("zb_e30_com", 32'(com0), 32'h7);
        33: chk_main("pos3_mask_a", 2'd3, 4'b1111);
        36: chk_main("pos3_mask_b", 2'd3, 4'b1111);
        39: chk_main("pos3_mask_c", 2'd3, 4'b1111);
        40: begin check("zb_e40_com", 32'(com0), 32'he);
                  check("zb_e40_pos", 32'(pos0), 32'd0); end
        default: ;
      endcase
    end

    // Run to pos 2 cnt 6, then drop enable
    for (int k = 41; k <= 66; k++) begin
      step();
      case (k)
        43: chk_main("pos0_drive", 2'd0, 4'b1110);
        53: chk_main("pos1_drive2", 2'd1, 4'b1101);
        63: chk_main("pos2_drive2", 2'd2, 4'b1011);
        default: ;
      endcase
    end
    en = 1'b0;

    for (int k = 67; k <= 73; k++) begin
      step();
      if (k == 67 || k == 70 || k == 73) chk_main("disabled", 2'd2, 4'b1111);
    end
    en    = 1'b1;
    e.cyc = t0 + 83;
    e.pos = 2'd3;
    e.com = 4'b1111;
    sb_q.push_back(e);

    // Fresh slot after re-enable, then reset mid-drive
    for (int k = 74; k <= 89; k++) begin
      step();
      case (k)
        74: chk_main("reen_blank_a", 2'd2, 4'b1111);
        75: chk_main("reen_blank_b", 2'd2, 4'b1111);
        76: chk_main("reen_drive", 2'd2, 4'b1011);
        83: chk_main("pos3_slot", 2'd3, 4'b1111);
        84: mask = 4'b0000;
        86: chk_main("pos3_drive", 2'd3, 4'b0111);
        88: rst_n = 1'b0;
        89: begin chk_main("midreset", 2'd0, 4'b1111);
                  check("midreset_tick", 32'(tick), 32'd0); end
        default: ;
      endcase
    end

    // Reset on the slot-end cycle suppresses the tick
    rst_n = 1'b1;
    t1    = cyc;
    repeat (9) step();
    check("pre_slot_end_cycle", 32'(cyc - t1), 32'd9);
    chk_main("pre_slot_end", 2'd0, 4'b1110);
    rst_n = 1'b0;
    step();
    chk_main("reset_at_end", 2'd0, 4'b1111);
    check("reset_at_end_tick", 32'(tick), 32'd0);

    repeat (3) step();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
